// File: rtl/uart_mmio_bridge.sv
// Memory-mapped CPU front end for uart_unit: four word registers, stalled TX stores,
// RX pops with a settle cycle, sticky error flags and a level interrupt.
module uart_mmio_bridge #(
  parameter int unsigned TX_TIMEOUT = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        uart_wr_en,
  output logic [7:0]  uart_wr_data,
  output logic        uart_cpu_read,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_ready,
  input  logic [31:0] uart_rx_data,
  output logic        irq
);

  localparam int CW = $clog2(TX_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, TX_WAIT, RX_HOLD, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          txdrop_q, txdrop_d;
  logic          rxempty_q, rxempty_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          ack_q, ack_d;
  logic [31:0]   bus_rdata_q, bus_rdata_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          cpu_read_q, cpu_read_d;

  logic       addr_hit;
  logic [1:0] reg_sel;
  logic       unused_bits;

  assign addr_hit    = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel     = bus_addr[3:2];
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8], uart_rx_data[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      txdrop_q    <= 1'b0;
      rxempty_q   <= 1'b0;
      rdata_q     <= '0;
      tx_byte_q   <= '0;
      ack_q       <= 1'b0;
      bus_rdata_q <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      cpu_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      txdrop_q    <= txdrop_d;
      rxempty_q   <= rxempty_d;
      rdata_q     <= rdata_d;
      tx_byte_q   <= tx_byte_d;
      ack_q       <= ack_d;
      bus_rdata_q <= bus_rdata_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      cpu_read_q  <= cpu_read_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    txdrop_d    = txdrop_q;
    rxempty_d   = rxempty_q;
    rdata_d     = rdata_q;
    tx_byte_d   = tx_byte_q;
    ack_d       = 1'b0;
    bus_rdata_d = '0;
    wr_en_d     = 1'b0;
    wr_data_d   = '0;
    cpu_read_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The request is still high in the cycle the ack is visible; don't restart on it.
        if (bus_req && !ack_q) begin
          rdata_d = '0;
          state_d = RESP;
          if (addr_hit) begin
            unique case (reg_sel)
              2'd0: begin
                if (bus_we) begin
                  tx_byte_d = bus_wdata[7:0];
                  if (uart_tx_ready) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = bus_wdata[7:0];
                  end else begin
                    state_d = TX_WAIT;
                    cnt_d   = '0;
                  end
                end
              end
              2'd1: begin
                if (!bus_we) begin
                  if (uart_rx_ready) begin
                    rdata_d    = {24'b0, uart_rx_data[7:0]};
                    cpu_read_d = 1'b1;
                    state_d    = RX_HOLD;
                  end else begin
                    rdata_d   = 32'h8000_0000;
                    rxempty_d = 1'b1;
                  end
                end
              end
              2'd2: begin
                if (bus_we) begin
                  txdrop_d  = txdrop_q & ~bus_wdata[4];
                  rxempty_d = rxempty_q & ~bus_wdata[3];
                end else begin
                  rdata_d = {27'b0, txdrop_q, rxempty_q, (state_q == TX_WAIT),
                             uart_tx_ready, uart_rx_ready};
                end
              end
              default: begin
                if (bus_we) ctrl_d = bus_wdata[1:0];
                else        rdata_d = {30'b0, ctrl_q};
              end
            endcase
          end
        end
      end
      TX_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A late tx_ready on the last allowed cycle still gets the byte through.
        if (uart_tx_ready) begin
          wr_en_d   = 1'b1;
          wr_data_d = tx_byte_q;
          state_d   = RESP;
        end else if (cnt_q == CW'(TX_TIMEOUT - 1)) begin
          txdrop_d = 1'b1;
          state_d  = RESP;
        end
      end
      RX_HOLD: state_d = RESP;
      default: begin
        ack_d       = 1'b1;
        bus_rdata_d = rdata_q;
        state_d     = IDLE;
      end
    endcase
  end

  assign bus_ack       = ack_q;
  assign bus_rdata     = bus_rdata_q;
  assign uart_wr_en    = wr_en_q;
  assign uart_wr_data  = wr_data_q;
  assign uart_cpu_read = cpu_read_q;
  assign irq           = (ctrl_q[0] & uart_rx_ready) | (ctrl_q[1] & uart_tx_ready) | txdrop_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge with hand-computed expectations and TX_TIMEOUT=16.
module tb_uart_mmio_bridge;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_req = 1'b0, bus_we = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ack, uart_wr_en, uart_cpu_read, irq;
  logic [7:0]  uart_wr_data;
  logic        uart_tx_ready = 1'b0, uart_rx_ready = 1'b0;
  logic [31:0] uart_rx_data = '0;

  int vecs = 0;
  int errs = 0;

  uart_mmio_bridge #(.TX_TIMEOUT(16), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .uart_wr_en(uart_wr_en), .uart_wr_data(uart_wr_data), .uart_cpu_read(uart_cpu_read),
    .uart_tx_ready(uart_tx_ready), .uart_rx_ready(uart_rx_ready), .uart_rx_data(uart_rx_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One bus access starting at a negedge; outputs sampled on negedges, k counts cycles
  // after the request was first presented. tx_rise>0 raises uart_tx_ready at negedge k.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int tx_rise, output logic [31:0] rdata, output int lat,
                      output int nwr, output int nrd, output int wr_k, output logic [7:0] wr_byte);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    lat = -1; nwr = 0; nrd = 0; wr_k = -1; wr_byte = '0; rdata = '0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (uart_wr_en) begin nwr++; wr_k = k; wr_byte = uart_wr_data; end
      if (uart_cpu_read) nrd++;
      if (bus_ack) begin lat = k; rdata = bus_rdata; break; end
      if (k == tx_rise) uart_tx_ready = 1'b1;
    end
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int lat, nwr, nrd, wk, extra;
    logic [7:0] wb;

    // Reset state
    #12;
    chk("rst_ack", {31'b0, bus_ack}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_wr_en", {31'b0, uart_wr_en}, 32'd0);
    chk("rst_cpu_read", {31'b0, uart_cpu_read}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Immediate TX push
    uart_tx_ready = 1'b1;
    xfer(1'b1, BASE + 32'h0, 32'h0000_0041, 0, rd, lat, nwr, nrd, wk, wb);
    $display("store TXDATA 0x41: lat=%0d pushes=%0d byte=%h at k=%0d", lat, nwr, wb, wk);
    chk("tx41_lat", lat, 2);
    chk("tx41_npush", nwr, 1);
    chk("tx41_byte", {24'b0, wb}, 32'h41);
    chk("tx41_push_cycle", wk, 1);
    chk("idle_rdata_zero", bus_rdata, 32'd0);

    // Stalled TX push, tx_ready raised after 10 cycles
    uart_tx_ready = 1'b0;
    xfer(1'b1, BASE + 32'h0, 32'h0000_0055, 10, rd, lat, nwr, nrd, wk, wb);
    $display("store TXDATA 0x55 stalled: lat=%0d pushes=%0d byte=%h at k=%0d", lat, nwr, wb, wk);
    chk("tx55_npush", nwr, 1);
    chk("tx55_byte", {24'b0, wb}, 32'h55);
    chk("tx55_push_cycle", wk, 11);
    chk("tx55_lat", lat, 12);

    // TX timeout: 16 wait cycles, no push, TXDROP set
    uart_tx_ready = 1'b0;
    xfer(1'b1, BASE + 32'h0, 32'h0000_0066, 0, rd, lat, nwr, nrd, wk, wb);
    $display("store TXDATA timeout: lat=%0d pushes=%0d", lat, nwr);
    chk("tmo_npush", nwr, 0);
    chk("tmo_lat", lat, 18);
    chk("tmo_irq", {31'b0, irq}, 32'd1);
    xfer(1'b0, BASE + 32'h8, 32'h0, 0, rd, lat, nwr, nrd, wk, wb);
    $display("load STATUS after timeout: rdata=%h", rd);
    chk("tmo_status", rd, 32'h0000_0010);
    uart_tx_ready = 1'b1;
    xfer(1'b1, BASE + 32'h8, 32'h0000_0010, 0, rd, lat, nwr, nrd, wk, wb);
    xfer(1'b0, BASE + 32'h8, 32'h0, 0, rd, lat, nwr, nrd, wk, wb);
    $display("load STATUS after W1C: rdata=%h", rd);
    chk("w1c_txdrop_status", rd, 32'h0000_0002);
    chk("w1c_txdrop_irq", {31'b0, irq}, 32'd0);

    // RX pop
    uart_rx_ready = 1'b1; uart_rx_data = 32'h0000_005A;
    xfer(1'b0, BASE + 32'h4, 32'h0, 0, rd, lat, nwr, nrd, wk, wb);
    $display("load RXDATA 0x5A: rdata=%h lat=%0d pops=%0d pushes=%0d", rd, lat, nrd, nwr);
    chk("rx5a_rdata", rd, 32'h0000_005A);
    chk("rx5a_lat", lat, 3);
    chk("rx5a_npop", nrd, 1);
    chk("rx5a_npush", nwr, 0);
    uart_rx_ready = 1'b0;

    // RX empty read, sticky flag, W1C
    xfer(1'b0, BASE + 32'h4, 32'h0, 0, rd, lat, nwr, nrd, wk, wb);
    $display("load RXDATA empty: rdata=%h lat=%0d pops=%0d", rd, lat, nrd);
    chk("rxe_rdata", rd, 32'h8000_0000);
    chk("rxe_lat", lat, 2);
    chk("rxe_npop", nrd, 0);
    xfer(1'b0, BASE + 32'h8, 32'h0, 0, rd, lat, nwr, nrd, wk, wb);
    $display("load STATUS after empty read: rdata=%h", rd);
    chk("rxe_status", rd, 32'h0000_000A);
    xfer(1'b1, BASE + 32'h8, 32'h0000_0018, 0, rd, lat, nwr, nrd, wk, wb);
    xfer(1'b0, BASE + 32'h8, 32'h0, 0, rd, lat, nwr, nrd, wk, wb);
    $display("load STATUS after W1C 0x18: rdata=%h", rd);
    chk("w1c_status", rd, 32'h0000_0002);

    // Read of TXDATA, write to RXDATA, out-of-range accesses
    xfer(1'b0, BASE + 32'h0, 32'h0, 0, rd, lat, nwr, nrd, wk, wb);
    $display("load TXDATA: rdata=%h pushes=%0d", rd, nwr);
    chk("txdata_read", rd, 32'd0);
    chk("txdata_read_npush", nwr, 0);
    uart_rx_ready = 1'b1; uart_rx_data = 32'h0000_0033;
    xfer(1'b1, BASE + 32'h4, 32'h0000_00FF, 0, rd, lat, nwr, nrd, wk, wb);
    $display("store RXDATA: pops=%0d lat=%0d", nrd, lat);
    chk("rxdata_write_npop", nrd, 0);
    xfer(1'b0, 32'h2000_0004, 32'h0, 0, rd, lat, nwr, nrd, wk, wb);
    $display("load out-of-range: rdata=%h lat=%0d pops=%0d", rd, lat, nrd);
    chk("oor_rdata", rd, 32'd0);
    chk("oor_lat", lat, 2);
    chk("oor_npop", nrd, 0);
    xfer(1'b1, 32'h2000_0000, 32'h0000_0077, 0, rd, lat, nwr, nrd, wk, wb);
    $display("store out-of-range: pushes=%0d", nwr);
    chk("oor_npush", nwr, 0);
    uart_rx_ready = 1'b0;

    // CTRL read/write and interrupt
    xfer(1'b1, BASE + 32'hC, 32'hFFFF_FFFF, 0, rd, lat, nwr, nrd, wk, wb);
    xfer(1'b0, BASE + 32'hC, 32'h0, 0, rd, lat, nwr, nrd, wk, wb);
    $display("load CTRL after 0xFFFFFFFF: rdata=%h", rd);
    chk("ctrl_all", rd, 32'h0000_0003);
    chk("irq_txspace", {31'b0, irq}, 32'd1);
    xfer(1'b1, BASE + 32'hC, 32'h0000_0001, 0, rd, lat, nwr, nrd, wk, wb);
    xfer(1'b0, BASE + 32'hC, 32'h0, 0, rd, lat, nwr, nrd, wk, wb);
    $display("load CTRL after 0x1: rdata=%h", rd);
    chk("ctrl_one", rd, 32'h0000_0001);
    chk("irq_rx_low", {31'b0, irq}, 32'd0);
    uart_rx_ready = 1'b1;
    #1;
    $display("irq after rx_ready rise: %b", irq);
    chk("irq_rx_rise", {31'b0, irq}, 32'd1);

    // Reset in the middle of TX_WAIT
    @(negedge clk);
    uart_tx_ready = 1'b0;
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = BASE; bus_wdata = 32'h0000_0099;
    repeat (3) @(negedge clk);
    chk("pre_rst_irq", {31'b0, irq}, 32'd1);
    rst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    #1;
    $display("reset in TX_WAIT: ack=%b wr_en=%b cpu_read=%b rdata=%h irq=%b",
             bus_ack, uart_wr_en, uart_cpu_read, bus_rdata, irq);
    chk("mid_rst_outputs", {bus_ack, uart_wr_en, uart_cpu_read, irq, 20'b0, uart_wr_data}, 32'd0);
    chk("mid_rst_rdata", bus_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1; uart_tx_ready = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (uart_wr_en || bus_ack) extra++;
    end
    chk("post_rst_no_push_ack", extra, 0);
    xfer(1'b1, BASE + 32'h0, 32'h0000_007E, 0, rd, lat, nwr, nrd, wk, wb);
    $display("store TXDATA 0x7E after reset: lat=%0d pushes=%0d byte=%h", lat, nwr, wb);
    chk("post_rst_byte", {24'b0, wb}, 32'h7E);
    chk("post_rst_lat", lat, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
